// File: rtl/gene_attractor_det.sv
// Records a gene-network state trajectory and reports transient length, cycle length and attractor state on the first repeat.
// done follows the closing sample by 1 cycle (cycle_len+1 with GENE_ATTR_MIN_EN); samples are taken only while in_rdy is high.
module gene_attractor_det #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          state_vld,
   input  logic [7:0]    state_in,
   output logic          in_rdy,
   output logic          done,
   output logic          found,
   output logic          overflow,
   output logic [CW-1:0] transient_len,
   output logic [CW-1:0] cycle_len,
   output logic [7:0]    attr_state,
   output logic [7:0]    attr_min
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} st_t;

   st_t           st;
   logic [7:0]    hist [DEPTH];
   logic [CW-1:0] count;
   logic          accept;
   logic          match;
   logic [CW-1:0] match_idx;
   logic          wr_en;
`ifdef GENE_ATTR_MIN_EN
   logic [CW-1:0] scan_idx;
`endif

   assign accept = state_vld & in_rdy;
   assign wr_en  = accept & ~match & (count != FULL);

   // Only entries below count are live; stale history from an earlier run never matches.
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count) && (hist[i] == state_in)) begin
            match     = 1'b1;
            match_idx = CW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         hist[count[AW-1:0]] <= state_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st            <= IDLE;
         count         <= '0;
         in_rdy        <= 1'b0;
         done          <= 1'b0;
         found         <= 1'b0;
         overflow      <= 1'b0;
         transient_len <= '0;
         cycle_len     <= '0;
         attr_state    <= '0;
         attr_min      <= '0;
`ifdef GENE_ATTR_MIN_EN
         scan_idx      <= '0;
`endif
      end else begin
         case (st)
            IDLE, DONE: begin
               if (start) begin
                  st            <= RUN;
                  count         <= '0;
                  in_rdy        <= 1'b1;
                  done          <= 1'b0;
                  found         <= 1'b0;
                  overflow      <= 1'b0;
                  transient_len <= '0;
                  cycle_len     <= '0;
                  attr_state    <= '0;
                  attr_min      <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (match) begin
                     found         <= 1'b1;
                     transient_len <= match_idx;
                     cycle_len     <= count - match_idx;
                     attr_state    <= state_in;
                     attr_min      <= state_in;
                     in_rdy        <= 1'b0;
`ifdef GENE_ATTR_MIN_EN
                     st            <= SCAN;
                     scan_idx      <= match_idx;
`else
                     st            <= DONE;
                     done          <= 1'b1;
`endif
                  end else if (count == FULL) begin
                     overflow <= 1'b1;
                     in_rdy   <= 1'b0;
                     done     <= 1'b1;
                     st       <= DONE;
                  end else begin
                     count <= count + ONE;
                  end
               end
            end
`ifdef GENE_ATTR_MIN_EN
            // One cycle entry per clock; the minimum is a rotation-invariant label.
            SCAN: begin
               if (hist[scan_idx[AW-1:0]] < attr_min)
                  attr_min <= hist[scan_idx[AW-1:0]];
               if (scan_idx == count - ONE) begin
                  st   <= DONE;
                  done <= 1'b1;
               end else begin
                  scan_idx <= scan_idx + ONE;
               end
            end
`endif
            default: st <= IDLE;
         endcase
      end
   end

endmodule
